// File: rtl/word_packer.sv
// word_packer: packs R=2**ratio_log2_p input words into one wide output word.
// Define WORD_PACKER_TIMEOUT_EN to flush a partial word after timeout_p idle cycles.
module word_packer #(
    parameter int width_p      = 32,
    parameter int ratio_log2_p = 2,
    parameter int timeout_p    = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  valid_i,
    input  logic [width_p-1:0]                    data_i,
    input  logic                                  last_i,
    output logic                                  ready_o,
    output logic                                  valid_o,
    output logic [width_p*(1<<ratio_log2_p)-1:0]  data_o,
    output logic [ratio_log2_p:0]                 count_o,
    output logic                                  last_o,
    input  logic                                  ready_i
);
    localparam int R  = 1 << ratio_log2_p;
    localparam int CW = ratio_log2_p + 1;
    localparam int DW = width_p * R;

    typedef enum logic {FILL, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   lanes_q;
    logic            last_q;
    logic            in_xfer;
    logic            out_xfer;
    logic            lane_full;
    logic            timeout;

    assign ready_o   = !reset_i && (state_q == FILL || ready_i);
    assign valid_o   = state_q == DONE;
    assign data_o    = lanes_q;
    assign count_o   = cnt_q;
    assign last_o    = last_q;
    assign in_xfer   = valid_i && ready_o;
    assign out_xfer  = valid_o && ready_i;
    assign lane_full = cnt_q == CW'(R - 1);

`ifdef WORD_PACKER_TIMEOUT_EN
    localparam int IW = $clog2(timeout_p + 1);

    logic [IW-1:0] idle_q;

    assign timeout = state_q == FILL && cnt_q != '0 && !in_xfer && idle_q == IW'(timeout_p - 1);

    always_ff @(posedge clk_i) begin
        if (reset_i || state_q != FILL || in_xfer || cnt_q == '0 || timeout)
            idle_q <= '0;
        else
            idle_q <= idle_q + 1'b1;
    end
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = timeout_p != 0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            lanes_q <= '0;
            last_q  <= 1'b0;
        end else if (state_q == FILL) begin
            if (in_xfer) begin
                lanes_q[int'(cnt_q[ratio_log2_p-1:0])*width_p +: width_p] <= data_i;
                cnt_q <= cnt_q + 1'b1;
                if (lane_full || last_i) begin
                    state_q <= DONE;
                    last_q  <= last_i;
                end
            end else if (timeout) begin
                state_q <= DONE;
                last_q  <= 1'b0;
            end
        end else if (out_xfer) begin
            // a word accepted alongside the hand-off starts a fresh word in lane 0
            lanes_q <= in_xfer ? DW'(data_i) : '0;
            cnt_q   <= in_xfer ? CW'(1) : '0;
            last_q  <= in_xfer && last_i;
            state_q <= (in_xfer && (last_i || R == 1)) ? DONE : FILL;
        end
    end
endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed vectors for word_packer at width 8, ratio 4, timeout 4.
module tb_word_packer;
    logic        clk_i = 1'b0;
    logic        reset_i, valid_i, last_i, ready_i;
    logic [7:0]  data_i;
    logic        ready_o, valid_o, last_o;
    logic [31:0] data_o;
    logic [2:0]  count_o;
    int          n_vec = 0;
    int          n_err = 0;

    word_packer #(.width_p(8), .ratio_log2_p(2), .timeout_p(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .last_i(last_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .count_o(count_o), .last_o(last_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
        #1;
    endtask

    task automatic word(input string tag, input logic [31:0] d, input logic [2:0] c, input logic l);
        chk({tag, "_valid"}, valid_o, 1'b1);
        chk({tag, "_data"}, data_o, d);
        chk({tag, "_count"}, count_o, c);
        chk({tag, "_last"}, last_o, l);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] p0, p1;
        reset_i = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        tick();
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_count", count_o, 3'd0);
        chk("rst_last", last_o, 1'b0);
        reset_i = 1'b0;
        #1;
        chk("fill_ready", ready_o, 1'b1);

        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("full_latency", valid_o, 1'b0);
        send(8'h44, 1'b0);
        word("full", 32'h44332211, 3'd4, 1'b0);
        tick();
        chk("full_drain", valid_o, 1'b0);

        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        word("last", 32'h0000BBAA, 3'd2, 1'b1);
        tick();
        chk("last_drain", valid_o, 1'b0);

        p0 = 32'h13121110;
        p1 = 32'h17161514;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h10 + 8'(i);
            #1;
            chk($sformatf("thru_ready%0d", i), ready_o, 1'b1);
            chk($sformatf("thru_valid%0d", i), valid_o, i == 4);
            if (i == 4) chk("thru_word0", data_o, p0);
            tick();
        end
        valid_i = 1'b0;
        #1;
        word("thru1", p1, 3'd4, 1'b0);

        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_ready%0d", i), ready_o, 1'b0);
            chk($sformatf("bp_data%0d", i), data_o, p1);
            chk($sformatf("bp_count%0d", i), count_o, 3'd4);
            chk($sformatf("bp_valid%0d", i), valid_o, 1'b1);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("bp_drain", valid_o, 1'b0);

        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_count", count_o, 3'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        word("postrst", 32'h04030201, 3'd4, 1'b0);
        tick();

        send(8'h5A, 1'b0);
`ifdef WORD_PACKER_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_valid%0d", i), valid_o, i == 4);
        end
        word("to", 32'h0000005A, 3'd1, 1'b0);
        tick();
        chk("to_drain", valid_o, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("noto_valid%0d", i), valid_o, 1'b0);
        end
        send(8'h6B, 1'b1);
        word("noto", 32'h00006B5A, 3'd2, 1'b1);
        tick();
        chk("noto_drain", valid_o, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter width_p, default 32, the input word width in bits (>=1).
REQ-002 SHALL have parameter ratio_log2_p, default 2, where log2 of input words per output word R = 1<<ratio_log2_p (>=1).
REQ-003 SHALL have parameter timeout_p, default 16, the idle cycles before a partial-word flush (>=1; used only under REQ-026).
REQ-004 clk_i  input  1  single clock; all logic on posedge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  input word valid; connects to the CDC FIFO pvalid_o.
REQ-007 data_i  input  width_p  input word; connects to the CDC FIFO pdata_o.
REQ-008 last_i  input  1  input word is the final word of a packet.
REQ-009 ready_o  output  1  packer accepts the input word this cycle; connects to the CDC FIFO pready_i.
REQ-010 valid_o  output  1  packed word valid.
REQ-011 data_o  output  width_p*R  packed word; lane k is bits [k*width_p +: width_p].
REQ-012 count_o  output  ratio_log2_p+1  number of filled lanes, 1..R, when valid_o=1.
REQ-013 last_o  output  1  packed word ends a packet.
REQ-014 ready_i  input  1  downstream accepts the packed word.

Function
REQ-015 An input transfer SHALL occur on a cycle with valid_i & ready_o; an output transfer SHALL occur on a cycle with valid_o & ready_i.
REQ-016 The block SHALL have two states: FILL (valid_o=0, lanes 0..cnt-1 held) and DONE (valid_o=1, word presented).
REQ-017 ready_o SHALL be 1 in FILL and SHALL equal ready_i in DONE, giving combinational backpressure and full throughput.
REQ-018 Accepted words SHALL fill lanes in ascending order from lane 0; unfilled lanes of a presented word SHALL read 0.
REQ-019 FILL->DONE SHALL occur on the input transfer that fills lane R-1 or carries last_i=1; last_o SHALL equal that last_i, and count_o SHALL equal the lanes filled.
REQ-020 DONE->FILL SHALL occur on an output transfer without a simultaneous input transfer; cnt and lanes SHALL clear.
REQ-021 When an output transfer and an input transfer occur in the same cycle, data_i SHALL load lane 0 of a cleared word with cnt=1. The state SHALL be DONE if last_i=1 or R=1, otherwise FILL.
REQ-022 Latency SHALL be exactly one cycle: valid_o rises on the cycle after the completing input transfer.
REQ-023 In DONE, data_o, count_o and last_o SHALL remain stable until the output transfer.
REQ-024 The lane counter SHALL never exceed R. At R lanes the state SHALL be DONE and no further word SHALL be accepted into the held word.

Reset
REQ-025 While reset_i=1 at a clock edge: state SHALL go to FILL, cnt=0, valid_o=0, data_o=0, count_o=0, last_o=0, ready_o=0 for that cycle, and any partial or presented word SHALL be discarded, including mid-packet.

Configuration
REQ-026 With macro WORD_PACKER_TIMEOUT_EN defined: in FILL with cnt>=1, after timeout_p consecutive cycles without an input transfer, the state SHALL go to DONE with the current count and last_o=0. The idle counter SHALL reset on every input transfer, on reset, and on leaving FILL.
REQ-027 Without WORD_PACKER_TIMEOUT_EN: no idle counter SHALL be built, a partial word SHALL be emitted only on last_i, and timeout_p SHALL be ignored.

Verification (width_p=8, ratio_log2_p=2, R=4, timeout_p=4)
REQ-028 Input 0x11,0x22,0x33,0x44 with last_i=0 and ready_i=1 -> one cycle after 0x44: valid_o=1, data_o=0x44332211, count_o=4, last_o=0.
REQ-029 Input 0xAA,0xBB with last_i=1 on 0xBB -> data_o=0x0000BBAA, count_o=2, last_o=1.
REQ-030 Continuous valid_i with ready_i=1 over 8 words -> ready_o held at 1 and 2 packed words on consecutive R-word boundaries. With ready_i=0 while in DONE -> ready_o=0 and outputs stable for 5 cycles.
REQ-031 Accept 2 words, assert reset_i for 1 cycle, then accept 0x01,0x02,0x03,0x04 -> data_o=0x04030201 with no residue from the pre-reset words.
REQ-032 With WORD_PACKER_TIMEOUT_EN: accept 0x5A, then hold valid_i=0 -> valid_o=1 after 4 idle cycles with data_o=0x0000005A, count_o=1, last_o=0. Without the macro -> valid_o stays 0 for 20 cycles.
